switch_input_controller: RTL



---
 rtl/switch_input_controller.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/switch_input_controller.sv
// Push-button front end: per-channel synchroniser, debounce, press/release
// edge pulses and hold-to-repeat, plus a timed all-pressed combo detector.
module switch_input_controller #(
    parameter int NUM_SWITCHES   = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_RATE    = 2500000,
    parameter int COMBO_HOLD     = 25000000
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst,
    input  logic [NUM_SWITCHES-1:0] i_Switch,
    input  logic [NUM_SWITCHES-1:0] i_Repeat_En,
    output logic [NUM_SWITCHES-1:0] o_Switch,
    output logic [NUM_SWITCHES-1:0] o_Press,
    output logic [NUM_SWITCHES-1:0] o_Release,
    output logic [NUM_SWITCHES-1:0] o_Repeat,
    output logic [NUM_SWITCHES-1:0] o_Step,
    output logic                    o_Combo,
    output logic                    o_Combo_Pulse
);

    localparam int DB_W    = $clog2(DEBOUNCE_LIMIT);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX);
    localparam int CB_W    = $clog2(COMBO_HOLD);

    localparam logic [DB_W-1:0]  DB_LAST    = DB_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);
    localparam logic [CB_W-1:0]  CB_LAST    = CB_W'(COMBO_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    logic [NUM_SWITCHES-1:0] sync1;
    logic [NUM_SWITCHES-1:0] sync2;
    logic [NUM_SWITCHES-1:0] stable;
    logic [NUM_SWITCHES-1:0] stable_d;
    logic [DB_W-1:0]         db_cnt [NUM_SWITCHES];

    logic [NUM_SWITCHES-1:0] press_edge;
    logic [NUM_SWITCHES-1:0] release_edge;

    rep_state_t              rep_state   [NUM_SWITCHES];
    rep_state_t              rep_state_n [NUM_SWITCHES];
    logic [REP_W-1:0]        rep_cnt     [NUM_SWITCHES];
    logic [REP_W-1:0]        rep_cnt_n   [NUM_SWITCHES];
    logic [NUM_SWITCHES-1:0] rep_fire;

    logic            all_held;
    logic [CB_W-1:0] cb_cnt;
    logic            combo_r;
    logic            combo_pulse_r;
    logic            combo_level;

    // Two-flop synchroniser followed by a restartable stability counter per channel.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int unsigned i = 0; i < NUM_SWITCHES; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1    <= i_Switch;
            sync2    <= sync1;
            stable_d <= stable;
            for (int unsigned i = 0; i < NUM_SWITCHES; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        stable[i] <= sync2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DB_W'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign press_edge   = stable & ~stable_d;
    assign release_edge = ~stable & stable_d;

    // Repeat FSM state register, one per channel.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            for (int unsigned i = 0; i < NUM_SWITCHES; i++) begin
                rep_state[i] <= IDLE;
                rep_cnt[i]   <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_SWITCHES; i++) begin
                rep_state[i] <= rep_state_n[i];
                rep_cnt[i]   <= rep_cnt_n[i];
            end
        end
    end

    // Repeat FSM next state; a disable or a debounced release wins over any pulse that cycle.
    always_comb begin
        rep_fire = '0;
        for (int unsigned i = 0; i < NUM_SWITCHES; i++) begin
            rep_state_n[i] = rep_state[i];
            rep_cnt_n[i]   = rep_cnt[i];
            if (!i_Repeat_En[i] || release_edge[i]) begin
                rep_state_n[i] = IDLE;
                rep_cnt_n[i]   = '0;
            end else begin
                case (rep_state[i])
                    IDLE: begin
                        if (press_edge[i]) begin
                            rep_state_n[i] = DELAY;
                            rep_cnt_n[i]   = '0;
                        end
                    end
                    DELAY: begin
                        if (rep_cnt[i] == DELAY_LAST) begin
                            rep_fire[i]    = 1'b1;
                            rep_state_n[i] = REPEAT;
                            rep_cnt_n[i]   = '0;
                        end else begin
                            rep_cnt_n[i] = rep_cnt[i] + REP_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (rep_cnt[i] == RATE_LAST) begin
                            rep_fire[i]  = 1'b1;
                            rep_cnt_n[i] = '0;
                        end else begin
                            rep_cnt_n[i] = rep_cnt[i] + REP_W'(1);
                        end
                    end
                    default: begin
                        rep_state_n[i] = IDLE;
                        rep_cnt_n[i]   = '0;
                    end
                endcase
            end
        end
    end

    assign all_held = &stable;

    // Combo hold counter saturates at its last value; flags are registered one cycle after it gets there.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            cb_cnt        <= '0;
            combo_r       <= 1'b0;
            combo_pulse_r <= 1'b0;
        end else begin
            if (!all_held) begin
                cb_cnt <= '0;
            end else if (cb_cnt != CB_LAST) begin
                cb_cnt <= cb_cnt + CB_W'(1);
            end
            combo_r       <= all_held && (cb_cnt == CB_LAST);
            combo_pulse_r <= all_held && (cb_cnt == CB_LAST) && !combo_r;
        end
    end

    // Gating with all_held lets the combo drop in the same cycle a debounced level falls.
    assign combo_level   = combo_r & all_held;
    assign o_Combo       = combo_level;
    assign o_Combo_Pulse = combo_pulse_r & all_held;

    assign o_Switch  = stable;
    assign o_Press   = press_edge;
    assign o_Release = release_edge;
    assign o_Repeat  = rep_fire & {NUM_SWITCHES{~combo_level}};
    assign o_Step    = press_edge | o_Repeat;

endmodule
